data_mem_access_unit: RTL and testbench

//   Initiator side of the data-memory interface: converts CPU load/store requests
//   (byte address, byte/half/word size) into word-wide accesses on the data memory port.
//   Sub-word stores use read-modify-write. Sub-word loads are extracted and sign- or

---
 rtl/data_mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// Load/store initiator for a word-addressed data memory: sub-word loads are extracted and
// extended; sub-word stores use read-modify-write. Optional macro MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module data_mem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misalign,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_mem_we,
    input  logic [31:0]       i_mem_data
);

    // state | meaning
    // IDLE  | waiting for i_req; latches the request
    // RD    | memory read cycle; load result or merged store word captured
    // WR    | single-cycle memory write
    // DONE  | o_done pulse, back to IDLE
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
    logic        reject;

`ifdef MISALIGN_TRAP_EN
    assign reject = ((i_size == 2'b01) && i_addr[0]) ||
                    (i_size[1] && (i_addr[1:0] != 2'b00));
`else
    assign reject     = 1'b0;
    assign o_misalign = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{~uns & b[7]}}, b};
            2'b01:   r = {{16{~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (off[1]) r[31:16] = d[15:0];
            else        r[15:0]  = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_off    <= 2'b00;
            lat_wdata  <= 32'h0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rdata    <= 32'h0;
            o_mem_addr <= '0;
            o_mem_data <= 32'h0;
            o_mem_we   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            o_misalign <= 1'b0;
`endif
        end else begin
            o_done   <= 1'b0;
            o_mem_we <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            o_misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (i_req) begin
                        lat_we    <= i_we;
                        lat_size  <= i_size;
                        lat_uns   <= i_unsigned;
                        lat_off   <= i_addr[1:0];
                        lat_wdata <= i_wdata;
                        o_busy    <= 1'b1;
                        if (reject) begin
                            // rejected access: no memory cycle, o_rdata left untouched
                            state  <= DONE;
                            o_done <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                            o_misalign <= 1'b1;
`endif
                        end else if (i_we && i_size[1]) begin
                            state      <= WR;
                            o_mem_addr <= i_addr[ADDR_W+1:2];
                            o_mem_data <= i_wdata;
                            o_mem_we   <= 1'b1;
                        end else begin
                            state      <= RD;
                            o_mem_addr <= i_addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: begin
                    if (lat_we) begin
                        state      <= WR;
                        o_mem_data <= merge(i_mem_data, lat_wdata, lat_size, lat_off);
                        o_mem_we   <= 1'b1;
                    end else begin
                        state   <= DONE;
                        o_rdata <= extract(i_mem_data, lat_size, lat_off, lat_uns);
                        o_done  <= 1'b1;
                    end
                end
                WR: begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: expectations queued at issue, popped by
// monitors on o_done and o_mem_we; a small word memory model answers the port.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misalign, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [6:0]  mem_addr;

    logic [31:0] mem [128];

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] last_rd = 32'h0;

    typedef struct { logic chk_rd; logic [31:0] rd; logic mis; } done_exp_t;
    typedef struct { logic [6:0] a; logic [31:0] d; } wr_exp_t;
    done_exp_t done_q[$];
    wr_exp_t   wr_q[$];

    always #5 clk = ~clk;

    data_mem_access_unit #(.ADDR_W(7)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
        .i_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .o_busy(busy),
        .o_done(done), .o_rdata(rdata), .o_misalign(misalign),
        .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .o_mem_we(mem_we),
        .i_mem_data(mem_rdata)
    );

    assign mem_rdata = mem_we ? 32'h0 : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin : done_mon
        done_exp_t e;
        if (!rst && done) begin
            if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e = done_q.pop_front();
                if (e.chk_rd) check("rdata", rdata, e.rd);
                check("misalign", {31'd0, misalign}, {31'd0, e.mis});
            end
        end
    end

    always @(negedge clk) begin : wr_mon
        wr_exp_t w;
        if (!rst && mem_we) begin
            if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", {25'd0, mem_addr}, {25'd0, w.a});
                check("wr_data", mem_wdata, w.d);
            end
        end
    end

    task automatic issue(input logic i_we, input logic [1:0] i_sz, input logic i_uns,
                         input logic [31:0] i_a, input logic [31:0] i_d, input int exp_lat,
                         input logic exp_wr, input logic [31:0] exp_wd,
                         input logic chk_rd, input logic [31:0] exp_rd, input logic exp_mis);
        int n;
        done_exp_t e;
        wr_exp_t   w;
        e.chk_rd = chk_rd; e.rd = exp_rd; e.mis = exp_mis;
        done_q.push_back(e);
        if (exp_wr) begin
            w.a = i_a[8:2]; w.d = exp_wd;
            wr_q.push_back(w);
        end
        @(posedge clk); #1;
        req = 1'b1; we = i_we; size = i_sz; uns = i_uns; addr = i_a; wdata = i_d;
        @(posedge clk); #1;
        req = 1'b0;
        n = 1;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, sz, u, a, 32'h0, 2, 1'b0, 32'h0, 1'b1, exp, 1'b0);
        last_rd = exp;
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_word);
        issue(1'b1, sz, 1'b0, a, d, sz[1] ? 2 : 3, 1'b1, exp_word, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        check("rst_mem_data", mem_wdata, 32'd0);
        rst = 1'b0;

        st(2'b10, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        ld(2'b00, 1'b0, 32'h13, 32'hFFFFFFDE);
        ld(2'b00, 1'b1, 32'h13, 32'h000000DE);
        ld(2'b01, 1'b0, 32'h12, 32'hFFFFDEAD);
        ld(2'b01, 1'b1, 32'h12, 32'h0000DEAD);
        st(2'b00, 32'h11, 32'h123456AA, 32'hDEADAAEF);
        st(2'b01, 32'h12, 32'h00005555, 32'h5555AAEF);
        ld(2'b10, 1'b0, 32'h10, 32'h5555AAEF);
        ld(2'b00, 1'b0, 32'h11, 32'hFFFFFFAA);
        ld(2'b00, 1'b1, 32'h12, 32'h00000055);
        ld(2'b01, 1'b0, 32'h10, 32'hFFFFAAEF);
        ld(2'b10, 1'b0, 32'h210, 32'h5555AAEF);
        ld(2'b11, 1'b0, 32'h10, 32'h5555AAEF);

`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1, 1'b0, 32'h0, 1'b1, last_rd, 1'b1);
`else
        ld(2'b10, 1'b0, 32'h11, 32'h5555AAEF);
`endif

        // request held high across a sub-word store
        begin
            done_exp_t e;
            wr_exp_t   w;
            e.chk_rd = 1'b0; e.rd = 32'h0; e.mis = 1'b0;
            done_q.push_back(e);
            w.a = 7'd12; w.d = 32'h00000077;
            wr_q.push_back(w);
            @(posedge clk); #1;
            req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h30; wdata = 32'h77;
            @(posedge clk); #1;
            check("hold_busy_c1", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            check("hold_busy_c2", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            check("hold_busy_c3", {31'd0, busy}, 32'd1);
            check("hold_done_c3", {31'd0, done}, 32'd1);
            req = 1'b0;
            @(posedge clk); #1;
            check("hold_busy_c4", {31'd0, busy}, 32'd0);
            check("hold_done_c4", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end

        // reset during the write cycle of a byte store
        st(2'b10, 32'h20, 32'h11223344, 32'h11223344);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h20; wdata = 32'hFF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("abort_we_in_wr", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_we_low", {31'd0, mem_we}, 32'd0);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ld(2'b10, 1'b0, 32'h20, 32'h11223344);

        repeat (3) @(posedge clk);
        #1;
        check("done_q_empty", done_q.size(), 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
